// File: rtl/hkspi_pkg.sv
// Housekeeping SPI responder: shared constants and types.
//   CMD_*          : command-byte mode field values (bits [7:6])
//   hkspi_state_e  : transaction states
//   BYTE_W         : SPI byte width
package hkspi_pkg;
    localparam int BYTE_W = 8;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_RW  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        DONE
    } hkspi_state_e;
endpackage

// File: rtl/hkspi_sync.sv
// Pad synchronizers for the housekeeping SPI inputs plus SCK edge detect.
// Ports:
//   clock, resetb        core clock, async active-low reset
//   spi_sck/csb/sdi      asynchronous pad inputs
//   csb_s, sdi_s         synchronized chip select / data in
//   sck_rise, sck_fall   one-cycle SCK edge pulses, suppressed while csb_s is high
module hkspi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic spi_sck,
    input  logic spi_csb,
    input  logic spi_sdi,
    output logic csb_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall
);
    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] csb_sr;
    logic [SYNC_STAGES-1:0] sdi_sr;
    logic                   sck_d;
    logic                   sck_s;

    // CSB resets to deselected so busy reads 0 out of reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sr <= '0;
            csb_sr <= '1;
            sdi_sr <= '0;
            sck_d  <= 1'b0;
        end else begin
            sck_sr <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            csb_sr <= {csb_sr[SYNC_STAGES-2:0], spi_csb};
            sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], spi_sdi};
            sck_d  <= sck_sr[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign csb_s    = csb_sr[SYNC_STAGES-1];
    assign sdi_s    = sdi_sr[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d & ~csb_s;
    assign sck_fall = ~sck_s &  sck_d & ~csb_s;
endmodule

// File: rtl/hkspi_slave.sv
// Housekeeping SPI responder (mode 0). Decodes command and address bytes and
// streams data bytes to/from a byte-wide register port with auto-increment.
// Optional build macro: HKSPI_FIXED_LEN_EN (command bits [5:3] = byte count).
// Ports:
//   clock, resetb                    core clock, async active-low reset
//   spi_sck/csb/sdi, spi_sdo(_oe)    SPI pad interface
//   reg_addr/wdata/we/re, reg_rdata  register-file port (rdata valid cycle after re)
//   busy                             synchronized CSB low
//
// state   | meaning
// IDLE    | deselected, waiting for CSB low
// COMMAND | shifting in the command byte
// ADDRESS | shifting in the address byte
// DATA    | streaming data bytes
// DONE    | ignoring SCK until CSB high
module hkspi_slave
    import hkspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              spi_sck,
    input  logic              spi_csb,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);
    logic                csb_s, sdi_s, sck_rise, sck_fall;
    hkspi_state_e        state_q, state_d;
    logic [2:0]          bit_cnt_q;
    logic [BYTE_W-2:0]   rx_q;
    logic [BYTE_W-1:0]   tx_q;
    logic [BYTE_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          mode_q;
    logic                re_q, we_q, ld_q, oe_q;
    logic                byte_done, last_byte;
    logic [BYTE_W-1:0]   rx_byte;
    logic [7:0]          addr_inc;

    hkspi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock    (clock),
        .resetb   (resetb),
        .spi_sck  (spi_sck),
        .spi_csb  (spi_csb),
        .spi_sdi  (spi_sdi),
        .csb_s    (csb_s),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q, sdi_s};
    // Increment wraps within the 8-bit address space.
    assign addr_inc  = addr_q[7:0] + 8'd1;

`ifdef HKSPI_FIXED_LEN_EN
    logic [2:0] len_q, byte_cnt_q;
    assign last_byte = (len_q != 3'd0) && ((byte_cnt_q + 3'd1) == len_q);
`else
    assign last_byte = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (csb_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = COMMAND;
                COMMAND: if (byte_done) state_d = (rx_byte[7:6] == CMD_NOP) ? DONE : ADDRESS;
                ADDRESS: if (byte_done) state_d = DATA;
                DATA:    if (byte_done && last_byte) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            mode_q    <= CMD_NOP;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            ld_q      <= 1'b0;
            oe_q      <= 1'b0;
`ifdef HKSPI_FIXED_LEN_EN
            len_q      <= '0;
            byte_cnt_q <= '0;
`endif
        end else begin
            re_q <= 1'b0;
            we_q <= 1'b0;
            ld_q <= re_q;
            if (csb_s) begin
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
                ld_q      <= 1'b0;
`ifdef HKSPI_FIXED_LEN_EN
                byte_cnt_q <= '0;
`endif
            end else begin
                if (sck_rise) begin
                    rx_q      <= rx_byte[BYTE_W-2:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                // Falls following rises 1..7 shift; the fall after the 8th
                // rise (bit_cnt back at 0) keeps the freshly loaded MSB.
                if (ld_q) begin
                    tx_q <= reg_rdata;
                    oe_q <= 1'b1;
                end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
                    tx_q <= tx_q << 1;
                end
                if (sck_fall && (state_q == DONE)) oe_q <= 1'b0;

                if (byte_done) begin
                    case (state_q)
                        COMMAND: begin
                            mode_q <= rx_byte[7:6];
`ifdef HKSPI_FIXED_LEN_EN
                            len_q  <= rx_byte[5:3];
`endif
                        end
                        ADDRESS: begin
                            addr_q <= ADDR_W'(rx_byte);
                            re_q   <= (mode_q == CMD_RD) || (mode_q == CMD_RW);
                        end
                        DATA: begin
                            if (mode_q == CMD_RD) begin
                                addr_q <= ADDR_W'(addr_inc);
                                re_q   <= 1'b1;
                            end
                            if ((mode_q == CMD_WR) || (mode_q == CMD_RW)) begin
                                we_q    <= 1'b1;
                                wdata_q <= rx_byte;
                            end
`ifdef HKSPI_FIXED_LEN_EN
                            byte_cnt_q <= byte_cnt_q + 3'd1;
`endif
                        end
                        default: ;
                    endcase
                end

                // Write lands at the current address, then the address moves
                // on; read-write mode fetches the next byte one cycle later.
                if (we_q) begin
                    addr_q <= ADDR_W'(addr_inc);
                    re_q   <= (mode_q == CMD_RW);
                end
            end
        end
    end

    assign spi_sdo    = oe_q & tx_q[BYTE_W-1];
    assign spi_sdo_oe = oe_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign busy       = ~csb_s;
endmodule
